// File: rtl/cpu_sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sram_arbiter_if
// Description : Bundles the instruction, data and memory-side SRAM-like
//               handshakes shared by the arbiter and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_addr_ok;
    logic [DATA_W-1:0] i_rdata;
    logic              i_data_ok;
    logic              i_cancel;

    // Data requester
    logic              d_req;
    logic              d_wr;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_addr_ok;
    logic [DATA_W-1:0] d_rdata;
    logic              d_data_ok;

    // Memory port
    logic              m_req;
    logic              m_wr;
    logic [1:0]        m_size;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_addr_ok;
    logic [DATA_W-1:0] m_rdata;
    logic              m_data_ok;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, i_cancel,
        input  d_req, d_wr, d_size, d_addr, d_wdata,
        input  m_addr_ok, m_rdata, m_data_ok,
        output i_addr_ok, i_rdata, i_data_ok,
        output d_addr_ok, d_rdata, d_data_ok,
        output m_req, m_wr, m_size, m_addr, m_wdata
    );

    // Environment view (CPU requesters plus memory model)
    modport master (
        output i_req, i_addr, i_cancel,
        output d_req, d_wr, d_size, d_addr, d_wdata,
        output m_addr_ok, m_rdata, m_data_ok,
        input  i_addr_ok, i_rdata, i_data_ok,
        input  d_addr_ok, d_rdata, d_data_ok,
        input  m_req, m_wr, m_size, m_addr, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sram_arbiter
// Description : Shares one SRAM-like memory port between the instruction and
//               data requesters, one transaction at a time, with fetch cancel.
//               Optional macro ARB_RR_EN selects round-robin arbitration;
//               otherwise D has fixed priority over I.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    cpu_sram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic       OWNER_I   = 1'b0;
    localparam logic       OWNER_D   = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              drop_q,  drop_d;
    logic              wr_q,    wr_d;
    logic [1:0]        size_q,  size_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic d_wins;
    logic grant_d;
    logic grant_i;
    logic resp;
    logic cancel_i;

`ifdef ARB_RR_EN
    logic last_q, last_d;

    // On a tie, the requester that lost the previous grant goes first.
    assign d_wins = (last_q == OWNER_I);

    always_comb begin
        last_d = last_q;
        if (grant_d) begin
            last_d = OWNER_D;
        end else if (grant_i) begin
            last_d = OWNER_I;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= OWNER_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign d_wins = 1'b1;
`endif

    // Grants are gated by resetn so addr_ok stays low while reset is held.
    assign grant_d  = resetn && (state_q == ST_IDLE) && bus.d_req
                      && (!bus.i_req || d_wins);
    assign grant_i  = resetn && (state_q == ST_IDLE) && bus.i_req && !grant_d;
    assign resp     = (state_q == ST_WAIT) && bus.m_data_ok;
    assign cancel_i = (owner_q == OWNER_I) && bus.i_cancel;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    owner_d = OWNER_D;
                    drop_d  = 1'b0;
                    wr_d    = bus.d_wr;
                    size_d  = bus.d_size;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    state_d = ST_REQ;
                end else if (grant_i) begin
                    owner_d = OWNER_I;
                    drop_d  = bus.i_cancel;
                    wr_d    = 1'b0;
                    size_d  = SIZE_WORD;
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // A cancelled fetch still runs on the memory port; only its
                // response is swallowed.
                if (cancel_i) begin
                    drop_d = 1'b1;
                end
                if (bus.m_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (resp) begin
                    drop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cancel_i) begin
                    drop_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_I;
            drop_q  <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.i_addr_ok = grant_i;
    assign bus.d_addr_ok = grant_d;

    assign bus.m_req   = (state_q == ST_REQ);
    assign bus.m_wr    = wr_q;
    assign bus.m_size  = size_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;

    // A cancel arriving with the response itself must also hide it.
    assign bus.d_data_ok = resp && (owner_q == OWNER_D);
    assign bus.i_data_ok = resp && (owner_q == OWNER_I) && !drop_q && !bus.i_cancel;

    assign bus.i_rdata = resetn ? bus.m_rdata : '0;
    assign bus.d_rdata = resetn ? bus.m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sram_arbiter
// Description : Directed self-checking bench for cpu_sram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sram_arbiter;

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_err;

    cpu_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        resetn        = 1'b0;
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0;
        bus.i_cancel  = 1'b0;
        bus.d_req     = 1'b1;
        bus.d_wr      = 1'b0;
        bus.d_size    = 2'd0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.m_addr_ok = 1'b0;
        bus.m_rdata   = 32'h0;
        bus.m_data_ok = 1'b0;

        // Reset state, with both requests held high
        #1;
        chk("rst_m_req",     32'(bus.m_req),     32'd0);
        chk("rst_i_addr_ok", 32'(bus.i_addr_ok), 32'd0);
        chk("rst_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);
        chk("rst_i_data_ok", 32'(bus.i_data_ok), 32'd0);
        chk("rst_d_data_ok", 32'(bus.d_data_ok), 32'd0);
        chk("rst_m_addr",    bus.m_addr,         32'h0);
        step();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // Basic I read
        step(); bus.i_req = 1'b1; bus.i_addr = 32'hBFC00000; #1;
        chk("t1_i_addr_ok", 32'(bus.i_addr_ok), 32'd1);
        chk("t1_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);
        chk("t1_m_req_c0",  32'(bus.m_req),     32'd0);
        step(); bus.i_req = 1'b0; bus.m_addr_ok = 1'b1; #1;
        chk("t1_m_req_c1",  32'(bus.m_req),     32'd1);
        chk("t1_m_addr",    bus.m_addr,         32'hBFC00000);
        chk("t1_m_size",    32'(bus.m_size),    32'd2);
        chk("t1_m_wr",      32'(bus.m_wr),      32'd0);
        step(); bus.m_addr_ok = 1'b0; #1;
        chk("t1_m_req_c2",  32'(bus.m_req),     32'd0);
        chk("t1_no_early",  32'(bus.i_data_ok), 32'd0);
        step(); bus.m_data_ok = 1'b1; bus.m_rdata = 32'h3C000001; #1;
        chk("t1_i_data_ok", 32'(bus.i_data_ok), 32'd1);
        chk("t1_i_rdata",   bus.i_rdata,        32'h3C000001);
        chk("t1_d_data_ok", 32'(bus.d_data_ok), 32'd0);
        step(); bus.m_data_ok = 1'b0; #1;
        chk("t1_pulse_end", 32'(bus.i_data_ok), 32'd0);

        // Simultaneous requests: D half-word write first, then I
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h80000100;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_size = 2'd1;
        bus.d_addr = 32'h80000010; bus.d_wdata = 32'h00001234; #1;
        chk("t2_d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
        chk("t2_i_addr_ok", 32'(bus.i_addr_ok), 32'd0);
        step(); bus.d_req = 1'b0; bus.m_addr_ok = 1'b1; #1;
        chk("t2_m_req",     32'(bus.m_req),     32'd1);
        chk("t2_m_wr",      32'(bus.m_wr),      32'd1);
        chk("t2_m_size",    32'(bus.m_size),    32'd1);
        chk("t2_m_addr",    bus.m_addr,         32'h80000010);
        chk("t2_m_wdata",   bus.m_wdata,        32'h00001234);
        chk("t2_i_blocked", 32'(bus.i_addr_ok), 32'd0);
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0; #1;
        chk("t2_d_data_ok", 32'(bus.d_data_ok), 32'd1);
        chk("t2_i_data_ok", 32'(bus.i_data_ok), 32'd0);
        chk("t2_i_wait",    32'(bus.i_addr_ok), 32'd0);
        step(); bus.m_data_ok = 1'b0; #1;
        chk("t2_i_grant",   32'(bus.i_addr_ok), 32'd1);
        step(); bus.i_req = 1'b0; bus.m_addr_ok = 1'b1; #1;
        chk("t2_i_m_addr",  bus.m_addr,         32'h80000100);
        chk("t2_i_m_wr",    32'(bus.m_wr),      32'd0);
        chk("t2_i_m_size",  32'(bus.m_size),    32'd2);
        chk("t2_i_m_wdata", bus.m_wdata,        32'h0);
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h11112222; #1;
        chk("t2_i_done",    32'(bus.i_data_ok), 32'd1);
        chk("t2_i_rdata",   bus.i_rdata,        32'h11112222);
        step(); bus.m_data_ok = 1'b0;

        // After grants D then I, a tie goes to D under either arbitration
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'hBFC00004;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h80000040; #1;
        chk("t2b_d_first",  32'(bus.d_addr_ok), 32'd1);
        chk("t2b_i_second", 32'(bus.i_addr_ok), 32'd0);
        step(); bus.d_req = 1'b0; bus.m_addr_ok = 1'b1;
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'hCAFEF00D; #1;
        chk("t2b_d_data_ok", 32'(bus.d_data_ok), 32'd1);
        chk("t2b_d_rdata",   bus.d_rdata,        32'hCAFEF00D);
        step(); bus.m_data_ok = 1'b0; #1;
        chk("t2b_i_grant",  32'(bus.i_addr_ok), 32'd1);
        step(); bus.i_req = 1'b0; bus.m_addr_ok = 1'b1;
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; #1;
        chk("t2b_i_done",   32'(bus.i_data_ok), 32'd1);
        step(); bus.m_data_ok = 1'b0;

        // m_addr_ok held off for 5 cycles while I keeps requesting
        step(); bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'h80000021; #1;
        chk("t3_d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
        step(); bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'hBFC00008;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            #1;
            chk("t3_m_req_hold",  32'(bus.m_req),     32'd1);
            chk("t3_m_addr_hold", bus.m_addr,         32'h80000021);
            chk("t3_m_size_hold", 32'(bus.m_size),    32'd0);
            chk("t3_no_i_ok",     32'(bus.i_addr_ok), 32'd0);
            chk("t3_no_d_ok",     32'(bus.d_addr_ok), 32'd0);
        end
        step(); bus.m_addr_ok = 1'b1; #1;
        chk("t3_m_req_c6",  32'(bus.m_req),     32'd1);
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0000005A; #1;
        chk("t3_d_data_ok", 32'(bus.d_data_ok), 32'd1);
        chk("t3_d_rdata",   bus.d_rdata,        32'h0000005A);
        step(); bus.m_data_ok = 1'b0; #1;
        chk("t3_i_grant",   32'(bus.i_addr_ok), 32'd1);

        // Cancel pulsed during WAIT of that I read
        step(); bus.i_req = 1'b0; bus.m_addr_ok = 1'b1; #1;
        chk("t4_m_addr",    bus.m_addr,         32'hBFC00008);
        step(); bus.m_addr_ok = 1'b0; bus.i_cancel = 1'b1; #1;
        chk("t4_wait_idle", 32'(bus.i_data_ok), 32'd0);
        step(); bus.i_cancel = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'hDEADBEEF; #1;
        chk("t4_dropped_i", 32'(bus.i_data_ok), 32'd0);
        chk("t4_dropped_d", 32'(bus.d_data_ok), 32'd0);
        step(); bus.m_data_ok = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'hBFC0000C; #1;
        chk("t4_next_grant", 32'(bus.i_addr_ok), 32'd1);
        step(); bus.i_req = 1'b0; bus.m_addr_ok = 1'b1; #1;
        chk("t4_next_addr", bus.m_addr,         32'hBFC0000C);
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h24020001; #1;
        chk("t4_next_data_ok", 32'(bus.i_data_ok), 32'd1);
        chk("t4_next_rdata",   bus.i_rdata,        32'h24020001);
        step(); bus.m_data_ok = 1'b0;

        // Cancel in the same cycle as the I grant
        step(); bus.i_req = 1'b1; bus.i_addr = 32'hBFC00010; bus.i_cancel = 1'b1; #1;
        chk("t5_grant",     32'(bus.i_addr_ok), 32'd1);
        step(); bus.i_req = 1'b0; bus.i_cancel = 1'b0; bus.m_addr_ok = 1'b1;
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; #1;
        chk("t5_dropped",   32'(bus.i_data_ok), 32'd0);
        step(); bus.m_data_ok = 1'b0;

        // Cancel in the same cycle as m_data_ok
        step(); bus.i_req = 1'b1; bus.i_addr = 32'hBFC00014; #1;
        chk("t6_grant",     32'(bus.i_addr_ok), 32'd1);
        step(); bus.i_req = 1'b0; bus.m_addr_ok = 1'b1;
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.i_cancel = 1'b1; #1;
        chk("t6_dropped",   32'(bus.i_data_ok), 32'd0);
        step(); bus.m_data_ok = 1'b0; bus.i_cancel = 1'b0;

        // Cancel has no effect on a D transaction
        step(); bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h80000080; #1;
        chk("t6d_grant",    32'(bus.d_addr_ok), 32'd1);
        step(); bus.d_req = 1'b0; bus.i_cancel = 1'b1; bus.m_addr_ok = 1'b1;
        step(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; #1;
        chk("t6d_data_ok",  32'(bus.d_data_ok), 32'd1);
        step(); bus.m_data_ok = 1'b0; bus.i_cancel = 1'b0;

        // Spurious m_data_ok in IDLE
        step(); bus.m_data_ok = 1'b1; #1;
        chk("t7_i_data_ok", 32'(bus.i_data_ok), 32'd0);
        chk("t7_d_data_ok", 32'(bus.d_data_ok), 32'd0);
        step(); bus.m_data_ok = 1'b0;

        // Asynchronous reset in the middle of WAIT
        step(); bus.i_req = 1'b1; bus.i_addr = 32'hBFC00018; #1;
        chk("t8_grant",     32'(bus.i_addr_ok), 32'd1);
        step(); bus.i_req = 1'b0; bus.m_addr_ok = 1'b1;
        step(); bus.m_addr_ok = 1'b0; #1;
        chk("t8_in_wait",   32'(bus.m_req),     32'd0);
        step(); resetn = 1'b0; bus.i_req = 1'b1; bus.m_rdata = 32'hFFFF0000; #1;
        chk("t8_m_req",     32'(bus.m_req),     32'd0);
        chk("t8_m_addr",    bus.m_addr,         32'h0);
        chk("t8_m_size",    32'(bus.m_size),    32'd0);
        chk("t8_i_addr_ok", 32'(bus.i_addr_ok), 32'd0);
        chk("t8_i_rdata",   bus.i_rdata,        32'h0);
        chk("t8_d_rdata",   bus.d_rdata,        32'h0);
        step(); resetn = 1'b1; bus.i_req = 1'b0;
        step(); bus.m_data_ok = 1'b1; #1;
        chk("t8_stray_i",   32'(bus.i_data_ok), 32'd0);
        chk("t8_stray_d",   32'(bus.d_data_ok), 32'd0);
        step(); bus.m_data_ok = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
